serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..64).
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start_in, input, 1 bit: request to begin an addition.
REQ-005 The block SHALL have port a_in, input, WIDTH bits: operand A, unsigned or two's complement.
REQ-006 The block SHALL have port b_in, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port c_in, input, 1 bit: carry-in.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port carry, output, 1 bit: registered carry-out of the MSB.
REQ-012 The block SHALL have port ovf, output, 1 bit: registered signed overflow, i.e. carry into MSB XOR carry out of MSB.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE, a rising edge with start_in=1 SHALL do all of: latch a_in, b_in and c_in into internal shift and carry registers; clear the bit counter; and enter RUN.
REQ-015 In IDLE, start_in=0 SHALL keep the block in IDLE with every output held.
REQ-016 Each RUN edge SHALL process exactly one bit, LSB first, through a single 1-bit full-adder slice: sum bit = a^b^c, carry = majority(a,b,c).
REQ-017 Each RUN edge SHALL shift the new sum bit into an internal result register, store the new carry in the carry flip-flop and increment the counter.
REQ-018 The counter SHALL be $clog2(WIDTH+1) bits wide.
REQ-019 On the RUN edge that processes bit WIDTH-1, the FSM SHALL enter DONE.
REQ-020 That same edge SHALL load sum, carry and ovf from the completed result.
REQ-021 DONE SHALL last exactly one cycle, with done=1, and the FSM SHALL then return to IDLE unconditionally.
REQ-022 Latency: if start is accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH.
REQ-023 The next start SHALL be accepted no earlier than edge k+WIDTH+1.
REQ-024 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-025 start_in SHALL be ignored in RUN and DONE; it SHALL NOT relatch operands or restart the counter.
REQ-026 a_in, b_in and c_in SHALL be don't-care except on the accepting edge.
REQ-027 sum, carry and ovf SHALL hold their last result until the next completion.
REQ-028 For WIDTH=1, the block SHALL reduce to a registered 1-bit full adder with 1-cycle RUN.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH.
REQ-030 {carry,sum} SHALL equal a_in+b_in+c_in exactly.

Reset
REQ-031 While rst_in=1 at a rising edge, the FSM SHALL go to IDLE and the counter, shift registers and carry flip-flop SHALL clear.
REQ-032 While rst_in=1 at a rising edge, outputs SHALL be busy=0, done=0, sum=0, carry=0 and ovf=0.
REQ-033 rst_in SHALL take priority over start_in.
REQ-034 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse.
REQ-035 The first start after reset release SHALL be accepted normally.

Verification (WIDTH=4 unless stated)
REQ-036 Reset -> with rst_in held 2 cycles, a bench SHALL see busy=0, done=0, sum=4'h0, carry=0 and ovf=0.
REQ-037 With a=4'h5, b=4'h3, c=0 and start accepted at edge k -> a bench SHALL see busy=1 for 5 cycles and done=1 only after edge k+4, with sum=4'h8, carry=0, ovf=1.
REQ-038 With a=4'hF, b=4'h1, c=0 -> a bench SHALL see sum=4'h0, carry=1, ovf=0.
REQ-039 With a=4'hF, b=4'hF, c=1 -> a bench SHALL see sum=4'hF, carry=1, ovf=0.
REQ-040 With a=4'h2, b=4'h2, c=0 started, then start_in=1 with a=4'h7, b=4'h7 pulsed during RUN -> a bench SHALL see a single done with sum=4'h4, and the second request ignored.
REQ-041 Reset asserted in the second RUN cycle -> a bench SHALL see IDLE the next cycle, no done, and outputs 0.
REQ-042 With WIDTH=1 and all 8 combinations of a, b, c -> a bench SHALL see {carry,sum} match the full-adder truth table, with done 1 cycle after acceptance.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice processes operands LSB first,
// producing a registered sum, carry-out and signed overflow after WIDTH cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             c_ff;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    s_bit    = a_sr[0] ^ b_sr[0] ^ c_ff;
    c_bit    = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_ff) | (b_sr[0] & c_ff);
    // Shift form keeps WIDTH=1 legal (no [0:1] slice).
    res_next = WIDTH'({s_bit, res_sr} >> 1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      c_ff   <= 1'b0;
      sum    <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            c_ff  <= c_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          c_ff   <= c_bit;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // c_ff here is the carry into the MSB slice.
            sum   <= res_next;
            carry <= c_bit;
            ovf   <= c_ff ^ c_bit;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=4 vectors, start/reset abuse,
// and a WIDTH=1 instance exercised over the full-adder truth table.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       c4 = 1'b0;
  logic       busy4, done4, carry4, ovf4;
  logic [3:0] sum4;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       c1 = 1'b0;
  logic       busy1, done1, carry1, ovf1;
  logic [0:0] sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(4)) dut4 (
    .clk_in(clk), .rst_in(rst), .start_in(start4),
    .a_in(a4), .b_in(b4), .c_in(c4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .ovf(ovf4)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk_in(clk), .rst_in(rst), .start_in(start1),
    .a_in(a1), .b_in(b1), .c_in(c1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .ovf(ovf1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts an addition, watches 12 cycles, then checks timing and result.
  // pulse_req>=0 re-asserts start with other operands in RUN and in DONE.
  task automatic run_add(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [3:0] es, input logic ec,
                         input logic eo, input int pulse_req);
    int busy_n = 0;
    int done_n = 0;
    int done_i = -1;
    @(negedge clk);
    a4 = a; b4 = b; c4 = c; start4 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy4) busy_n++;
      if (done4) begin
        done_n++;
        done_i = i;
      end
      start4 = (pulse_req >= 0) && (i == pulse_req || i == 4);
      a4 = 4'h7; b4 = 4'h7; c4 = 1'b1;
    end
    start4 = 1'b0;
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd5);
    check({tag, "_done_count"}, 64'(done_n), 64'd1);
    check({tag, "_done_cycle"}, 64'(done_i), 64'd4);
    check({tag, "_sum"}, 64'(sum4), 64'(es));
    check({tag, "_carry"}, 64'(carry4), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf4), 64'(eo));
    check({tag, "_idle_after"}, 64'(busy4), 64'd0);
  endtask

  initial begin
    logic [15:0] fa_tab;
    int          late_done;
    fa_tab = 16'b11_10_10_01_10_01_01_00;

    repeat (2) @(negedge clk);
    check("rst_busy4", 64'(busy4), 64'd0);
    check("rst_done4", 64'(done4), 64'd0);
    check("rst_sum4", 64'(sum4), 64'd0);
    check("rst_carry4", 64'(carry4), 64'd0);
    check("rst_ovf4", 64'(ovf4), 64'd0);
    check("rst_w1_all", 64'({busy1, done1, sum1, carry1, ovf1}), 64'd0);
    rst = 1'b0;

    run_add("add_5_3", 4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1, -1);
    run_add("add_f_1", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, -1);
    run_add("add_f_f_c", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, -1);
    run_add("add_2_2_ign", 4'h2, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0, 1);
    run_add("add_9_6_c", 4'h9, 4'h6, 1'b1, 4'h0, 1'b1, 1'b0, -1);
    run_add("add_7_1", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, -1);
    run_add("add_8_8", 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, -1);

    // Reset in the second RUN cycle after a result with nonzero flags.
    @(negedge clk);
    a4 = 4'h5; b4 = 4'h3; c4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy4), 64'd0);
    check("abort_done", 64'(done4), 64'd0);
    check("abort_outs", 64'({sum4, carry4, ovf4}), 64'd0);
    late_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4 || busy4) late_done++;
    end
    check("abort_no_done", 64'(late_done), 64'd0);

    run_add("after_rst_3_4", 4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 1'b1, -1);

    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp_cs;
      exp_cs = fa_tab[2*i +: 2];
      @(negedge clk);
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); c1 = 1'(i); start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; a1 = ~a1; b1 = ~b1; c1 = ~c1;
      check($sformatf("w1_run_%0d", i), 64'({busy1, done1}), 64'b10);
      @(negedge clk);
      check($sformatf("w1_done_%0d", i), 64'({busy1, done1}), 64'b11);
      check($sformatf("w1_cs_%0d", i), 64'({carry1, sum1}), 64'(exp_cs));
      check($sformatf("w1_ovf_%0d", i), 64'(ovf1), 64'(exp_cs[1] ^ i[0]));
      @(negedge clk);
      check($sformatf("w1_idle_%0d", i), 64'({busy1, done1}), 64'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
